// File: rtl/data_mem_responder_if.sv
// Load/store port between the core and the data memory responder.
// The core drives the request fields; the responder drives the results.
interface data_mem_responder_if;
    logic        memory_en;
    logic [1:0]  store_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_read_data_valid;
    logic        mem_write_ready;
    logic        busy;
    logic        access_err;

    modport master (
        output memory_en, store_size, mem_addr, mem_write_data,
        input  mem_read_data, mem_read_data_valid, mem_write_ready,
        input  busy, access_err
    );

    modport slave (
        input  memory_en, store_size, mem_addr, mem_write_data,
        output mem_read_data, mem_read_data_valid, mem_write_ready,
        output busy, access_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM behind the core's load/store port.
// Fixed-latency responses with programmable wait states and fault pulses.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic                 CLK,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        valid_q, valid_d;
    logic        wready_q, wready_d;
    logic        err_q, err_d;

    logic [31:0] ram_q [DEPTH_WORDS];

    logic [31:0] rel;
    logic [AW-1:0] idx;
    logic [1:0]  off;
    logic [4:0]  sh;
    logic        is_read;
    logic        fault;
    logic        ram_we;
    logic [31:0] cur_word;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    assign rel      = addr_q - BASE_ADDR;
    assign idx      = rel[AW+1:2];
    assign off      = addr_q[1:0];
    assign sh       = {off, 3'b000};
    assign is_read  = (size_q == 2'b11);
    assign cur_word = ram_q[idx];

    // Addresses below BASE_ADDR wrap to a huge offset and fail the span test.
    assign fault = (rel >= SPAN)
                 || (size_q == 2'b01 && off[0])
                 || (size_q == 2'b10 && off != 2'b00);

    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = wdata_q;
        unique case (size_q)
            2'b00: begin
                lane_mask = 32'h0000_00FF << sh;
                lane_data = wdata_q << sh;
            end
            2'b01: begin
                lane_mask = 32'h0000_FFFF << sh;
                lane_data = wdata_q << sh;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
        wready_d = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.memory_en) begin
                    size_d  = bus.store_size;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_write_data;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                err_d   = fault;
                if (is_read) begin
                    valid_d = 1'b1;
                    rdata_d = fault ? 32'h0 : (cur_word >> sh);
                end else begin
                    wready_d = 1'b1;
                    merge_d  = (cur_word & ~lane_mask)
                             | (lane_data & lane_mask);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            wready_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            wready_q <= wready_d;
            err_q    <= err_d;
        end
    end

    // The merged word commits at the end of the response cycle.
    assign ram_we = (state_q == S_RESP) && !is_read && !err_q && !reset;

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram_q[idx] <= merge_q;
        end
    end

    assign bus.mem_read_data       = rdata_q;
    assign bus.mem_read_data_valid = valid_q;
    assign bus.mem_write_ready     = wready_q;
    assign bus.access_err          = err_q;
    assign bus.busy                = (state_q != S_IDLE);
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store port.
- Accepts requests: memory_en, store_size, mem_addr, mem_write_data.
- Serves them from an internal word-organised RAM with a programmable number of wait states.
- Returns read data with mem_read_data_valid, or acknowledges writes with mem_write_ready. The core stalls until one of these pulses.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two, >= 4)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned)
WAIT_STATES, 0, extra cycles between request acceptance and response (0..15)

Ports:
CLK  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
memory_en  in  1  request valid; core holds it and all request fields stable until response
store_size  in  2  00 byte write, 01 half write, 10 word write, 11 read
mem_addr  in  32  byte address
mem_write_data  in  32  write data, right-aligned (byte in [7:0], half in [15:0])
mem_read_data  out  32  read data, right-aligned; holds last read value
mem_read_data_valid  out  1  one-cycle pulse: read complete, mem_read_data valid
mem_write_ready  out  1  one-cycle pulse: write committed
busy  out  1  high from acceptance through response cycle
access_err  out  1  one-cycle pulse alongside the response of a faulted request

Behaviour:
- Reset: all outputs = 0, FSM = IDLE, wait counter = 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: when memory_en=1, latch store_size, mem_addr and mem_write_data.
  - If WAIT_STATES=0, go to ACCESS.
  - Otherwise load counter = WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each cycle; at 0 go to ACCESS.
- ACCESS: synchronous RAM read of word index = (addr-BASE_ADDR)>>2.
  - Write: read-modify-write merge prepared here.
- RESP: exactly one cycle; return to IDLE.
  - Read: mem_read_data_valid=1 and mem_read_data updated in the same cycle.
  - Write: RAM write commits, mem_write_ready=1.
- Latency: from the cycle memory_en is accepted, the response pulse appears WAIT_STATES+2 cycles later.
- The request still held during RESP is not re-accepted. The next acceptance is at the earliest in the cycle after RESP (IDLE).
- Back-to-back requests therefore occupy WAIT_STATES+3 cycles each.
- Lane steering uses off = addr[1:0].
  - Write byte: data[7:0] goes to byte lane off.
  - Write half: data[15:0] goes to lanes off..off+1.
  - Write word: full word.
  - Unwritten lanes keep their old value.
- Read: the full word is shifted right by 8*off, so the byte or half at addr appears in bits [7:0]/[15:0].
  - The core performs sign/zero extension.
- Read returns the full shifted word regardless of the eventual load width.
- Faults (access_err=1 in RESP, no RAM write, read data = 0, the response pulse is still issued so the core never hangs):
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
- Read faults are detected from the address alone; reads have no size field, so misaligned reads are not faulted.
  - Exception: reads at off=3 are legal and return byte 3 in [7:0].
- Reset mid-operation (any non-IDLE state): abort, no RAM write, no response pulse, outputs = 0 next cycle.
- memory_en deasserting before the response (a protocol violation): the request completes anyway, and the response is pulsed.
- mem_read_data_valid and mem_write_ready are never high in the same cycle, and never high for more than one cycle per request.

Test Plan:
1. WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10 -> mem_write_ready pulses 2 cycles after accept; read returns 0xDEADBEEF with valid exactly 2 cycles after accept.
2. Byte write 0xA5 to 0x13 over word 0x11223344 -> read 0x10 returns 0xA5223344; read 0x13 returns 0x000000A5 in low byte (0x000000A5).
3. Half write 0xCAFE to 0x12, then read 0x12 -> bits [15:0]=0xCAFE; half write to 0x11 -> access_err pulse with mem_write_ready; RAM unchanged.
4. WAIT_STATES=3, two back-to-back reads with memory_en held high -> each valid pulse 5 cycles after its accept, 6-cycle spacing, no duplicate response for the held request.
5. Read address BASE_ADDR+4*DEPTH_WORDS -> valid pulse with mem_read_data=0 and access_err=1.
6. Assert reset during WAIT of a write (WAIT_STATES=3) -> no mem_write_ready, busy=0 next cycle, subsequent read shows the old data.
